// File: rtl/text_window_pipe.sv
// rtl/text_window_pipe.sv - scaled ROWS x COLS text window renderer with cursor blink
// Coordinates in, one pixel out per cycle, 3+ROM_LAT cycles later.
module text_window_pipe #(
  parameter int FONT_W       = 8,
  parameter int FONT_H       = 16,
  parameter int COLS         = 32,
  parameter int ROWS         = 8,
  parameter int SCALE        = 1,
  parameter int ROM_LAT      = 1,
  parameter int BLINK_FRAMES = 30,
  localparam int AW  = $clog2(ROWS*COLS),
  localparam int FAW = $clog2(256*FONT_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pos_x,
  input  logic [15:0]       pos_y,
  input  logic [15:0]       horz_coord,
  input  logic [15:0]       vert_coord,
  input  logic              coord_valid,
  input  logic              frame_tick,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              cursor_en,
  input  logic [AW-1:0]     cursor_addr,
  output logic [FAW-1:0]    font_addr,
  input  logic [FONT_W-1:0] font_row,
  output logic              pixel,
  output logic              pixel_valid,
  output logic              in_window
);

  localparam int NCELL = ROWS*COLS;
  localparam int BW    = $clog2(FONT_W);
  localparam int GHW   = $clog2(FONT_H);
  localparam int SSH   = $clog2(SCALE);
  localparam int BCW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [16:0] WIN_W   = 17'(COLS*FONT_W*SCALE);
  localparam logic [16:0] WIN_H   = 17'(ROWS*FONT_H*SCALE);
  localparam logic [AW:0] NCELL_V = (AW+1)'(NCELL);

  // S0 combinational decode
  logic          inside0_d;
  logic [15:0]   dx, dy, gx, gy;
  logic [AW-1:0] idx0_d;

  always_comb begin
    inside0_d = ({1'b0, horz_coord} >= {1'b0, pos_x}) &&
                ({1'b0, horz_coord} <  ({1'b0, pos_x} + WIN_W)) &&
                ({1'b0, vert_coord} >= {1'b0, pos_y}) &&
                ({1'b0, vert_coord} <  ({1'b0, pos_y} + WIN_H));
    dx = horz_coord - pos_x;
    dy = vert_coord - pos_y;
    gx = dx >> SSH;
    gy = dy >> SSH;
    idx0_d = '0;
    if (inside0_d) begin
      idx0_d = AW'(gy >> GHW) * AW'(COLS) + AW'(gx >> BW);
    end
  end

  logic          ins0_q, val0_q;
  logic [BW-1:0] bit0_q;
  logic [GHW-1:0] grow0_q;
  logic [AW-1:0] idx0_q;

  logic          ins1_q, val1_q, hit1_q;
  logic [BW-1:0] bit1_q;
  logic [GHW-1:0] grow1_q;
  logic [7:0]    code1_q;
  logic          hit1_d;

  logic [FAW-1:0]             font_addr_q;
  logic [ROM_LAT:0]           ins_dq, val_dq, hit_dq;
  logic [ROM_LAT:0][BW-1:0]   bit_dq;

  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_phase_q, blink_phase_d;

  // Character RAM: read-before-write, contents survive reset
  logic [7:0] mem [NCELL];

  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < NCELL_V)) begin
      mem[wr_addr] <= wr_data;
    end
    code1_q <= mem[idx0_q];
  end

  always_comb begin
    hit1_d = cursor_en && ins0_q && ({1'b0, cursor_addr} < NCELL_V) &&
             (idx0_q == cursor_addr);
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_tick) begin
      if (blink_cnt_q == BCW'(BLINK_FRAMES-1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ins0_q        <= 1'b0;
      val0_q        <= 1'b0;
      bit0_q        <= '0;
      grow0_q       <= '0;
      idx0_q        <= '0;
      ins1_q        <= 1'b0;
      val1_q        <= 1'b0;
      hit1_q        <= 1'b0;
      bit1_q        <= '0;
      grow1_q       <= '0;
      font_addr_q   <= '0;
      ins_dq        <= '0;
      val_dq        <= '0;
      hit_dq        <= '0;
      bit_dq        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      ins0_q        <= inside0_d;
      val0_q        <= coord_valid;
      bit0_q        <= gx[BW-1:0];
      grow0_q       <= gy[GHW-1:0];
      idx0_q        <= idx0_d;
      ins1_q        <= ins0_q;
      val1_q        <= val0_q;
      hit1_q        <= hit1_d;
      bit1_q        <= bit0_q;
      grow1_q       <= grow0_q;
      font_addr_q   <= {code1_q, grow1_q};
      ins_dq[0]     <= ins1_q;
      val_dq[0]     <= val1_q;
      hit_dq[0]     <= hit1_q;
      bit_dq[0]     <= bit1_q;
      for (int i = 1; i <= ROM_LAT; i++) begin
        ins_dq[i] <= ins_dq[i-1];
        val_dq[i] <= val_dq[i-1];
        hit_dq[i] <= hit_dq[i-1];
        bit_dq[i] <= bit_dq[i-1];
      end
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // FONT_W is a power of two, so FONT_W-1-bit is just the bitwise complement
  logic fg;
  always_comb begin
    fg          = font_row[~bit_dq[ROM_LAT]];
    pixel       = ins_dq[ROM_LAT] & val_dq[ROM_LAT] &
                  (fg ^ (hit_dq[ROM_LAT] & blink_phase_q));
    pixel_valid = val_dq[ROM_LAT];
    in_window   = ins_dq[ROM_LAT] & val_dq[ROM_LAT];
    font_addr   = font_addr_q;
  end

endmodule

// File: tb/tb_text_window_pipe.sv
// tb/tb_text_window_pipe.sv - directed bench for text_window_pipe
module tb_text_window_pipe;

  localparam int L = 4;

  logic        clk, rst;
  logic [15:0] pos_x, pos_y, horz_coord, vert_coord;
  logic        coord_valid, frame_tick, wr_en, cursor_en;
  logic [7:0]  wr_addr, wr_data, cursor_addr;
  logic [11:0] font_addr_a, font_addr_b;
  logic [7:0]  font_row_a, font_row_b;
  logic        pixel_a, pixel_valid_a, in_window_a;
  logic        pixel_b, pixel_valid_b, in_window_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic        raw_pix_a [0:511];
  logic        raw_pv_a  [0:511];
  logic        raw_win_a [0:511];
  logic        raw_pix_b [0:511];
  logic [11:0] raw_fa_a  [0:511];
  logic [11:0] raw_fa_b  [0:511];

  text_window_pipe #(.SCALE(1), .ROM_LAT(1), .BLINK_FRAMES(2)) dut_a (
    .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y),
    .horz_coord(horz_coord), .vert_coord(vert_coord), .coord_valid(coord_valid),
    .frame_tick(frame_tick), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_en(cursor_en), .cursor_addr(cursor_addr), .font_addr(font_addr_a),
    .font_row(font_row_a), .pixel(pixel_a), .pixel_valid(pixel_valid_a),
    .in_window(in_window_a)
  );

  text_window_pipe #(.SCALE(2), .ROM_LAT(1), .BLINK_FRAMES(2)) dut_b (
    .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y),
    .horz_coord(horz_coord), .vert_coord(vert_coord), .coord_valid(coord_valid),
    .frame_tick(frame_tick), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_en(cursor_en), .cursor_addr(cursor_addr), .font_addr(font_addr_b),
    .font_row(font_row_b), .pixel(pixel_b), .pixel_valid(pixel_valid_b),
    .in_window(in_window_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model font: 'A' row 3 = 0x66, 'B' every row = 0x80, 'C' every row = 0xFF
  function automatic logic [7:0] rom_fn(input logic [11:0] a);
    logic [7:0] c;
    logic [3:0] r;
    c = a[11:4];
    r = a[3:0];
    case (c)
      8'h41:   rom_fn = (r == 4'd3) ? 8'h66 : 8'h00;
      8'h42:   rom_fn = 8'h80;
      8'h43:   rom_fn = 8'hFF;
      default: rom_fn = 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    font_row_a <= rom_fn(font_addr_a);
    font_row_b <= rom_fn(font_addr_b);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_cell(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  // Output for coordinate k lands in raw[k+L]; optional write at iteration wr_iter
  task automatic sweep(input int y, input int x0, input int n, input int wr_iter,
                       input logic [7:0] wa, input logic [7:0] wd);
    for (int i = 0; i < n + L; i++) begin
      @(negedge clk);
      raw_pix_a[i] = pixel_a;
      raw_pv_a[i]  = pixel_valid_a;
      raw_win_a[i] = in_window_a;
      raw_pix_b[i] = pixel_b;
      raw_fa_a[i]  = font_addr_a;
      raw_fa_b[i]  = font_addr_b;
      if (i < n) begin
        horz_coord  = 16'(x0 + i);
        vert_coord  = 16'(y);
        coord_valid = 1'b1;
      end else begin
        coord_valid = 1'b0;
      end
      wr_en   = (i == wr_iter);
      wr_addr = wa;
      wr_data = wd;
    end
    wr_en = 1'b0;
    coord_valid = 1'b0;
  endtask

  logic [7:0] exp_row;

  initial begin
    rst = 1'b1; pos_x = 0; pos_y = 0; horz_coord = 0; vert_coord = 0;
    coord_valid = 0; frame_tick = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    cursor_en = 0; cursor_addr = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_pixel", pixel_a, 0);
    check_eq("rst_pixel_valid", pixel_valid_a, 0);
    check_eq("rst_in_window", in_window_a, 0);
    check_eq("rst_font_addr", font_addr_a, 0);
    rst = 1'b0;

    write_cell(8'd0, 8'h41);
    write_cell(8'd3, 8'h43);
    write_cell(8'd4, 8'h00);
    write_cell(8'd5, 8'h00);

    // Test 1: 'A' row 3 across cell 0
    sweep(3, 0, 8, -1, 0, 0);
    exp_row = 8'h66;
    check_eq("t1_valid_before_L", raw_pv_a[L-1], 0);
    check_eq("t1_valid_at_L", raw_pv_a[L], 1);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("t1_pix_x%0d", k), raw_pix_a[k+L], exp_row[7-k]);
    end

    // Test 2: window extent at pos 100,50
    pos_x = 16'd100; pos_y = 16'd50;
    sweep(50, 99, 258, -1, 0, 0);
    check_eq("t2_win_before_L", raw_win_a[L-1], 0);
    check_eq("t2_win_x99", raw_win_a[0+L], 0);
    check_eq("t2_win_x100", raw_win_a[1+L], 1);
    check_eq("t2_win_x355", raw_win_a[256+L], 1);
    check_eq("t2_win_x356", raw_win_a[257+L], 0);
    sweep(177, 100, 1, -1, 0, 0);
    check_eq("t2_win_y177", raw_win_a[L], 1);
    sweep(178, 100, 1, -1, 0, 0);
    check_eq("t2_win_y178", raw_win_a[L], 0);
    pos_x = 16'hFF80; pos_y = 16'd0;
    sweep(0, 16'hFFF0, 1, -1, 0, 0);
    check_eq("t2_win_hi_edge", raw_win_a[L], 1);
    sweep(0, 16, 1, -1, 0, 0);
    check_eq("t2_win_no_wrap", raw_win_a[L], 0);

    // Test 3: SCALE=2 instance, glyph 0x80 in cell 0
    pos_x = 16'd0; pos_y = 16'd0;
    write_cell(8'd0, 8'h42);
    sweep(6, 0, 16, -1, 0, 0);
    check_eq("t3_pix_x0", raw_pix_b[0+L], 1);
    check_eq("t3_pix_x1", raw_pix_b[1+L], 1);
    check_eq("t3_pix_x2", raw_pix_b[2+L], 0);
    check_eq("t3_pix_x15", raw_pix_b[15+L], 0);
    check_eq("t3_font_addr_s2", raw_fa_b[3], 12'h423);
    check_eq("t3_font_addr_s1", raw_fa_a[3], 12'h426);

    // Test 5: same-cycle write/read of cell 3 returns old code
    sweep(3, 24, 1, 1, 8'd3, 8'h41);
    check_eq("t5_old_code", raw_pix_a[L], 1);
    sweep(4, 24, 1, -1, 0, 0);
    check_eq("t5_new_code", raw_pix_a[L], 0);

    // Test 4: cursor on cell 5, blink every 2 frame ticks
    cursor_en = 1'b1; cursor_addr = 8'd5;
    sweep(3, 40, 1, -1, 0, 0);
    check_eq("t4_phase0", raw_pix_a[L], 0);
    tick();
    sweep(3, 40, 1, -1, 0, 0);
    check_eq("t4_one_tick", raw_pix_a[L], 0);
    tick();
    sweep(3, 32, 16, -1, 0, 0);
    check_eq("t4_cell4_x32", raw_pix_a[0+L], 0);
    check_eq("t4_cell4_x39", raw_pix_a[7+L], 0);
    check_eq("t4_cell5_x40", raw_pix_a[8+L], 1);
    check_eq("t4_cell5_x47", raw_pix_a[15+L], 1);
    tick();
    tick();
    sweep(3, 40, 1, -1, 0, 0);
    check_eq("t4_back_normal", raw_pix_a[L], 0);

    // Test 6: reset mid-line with inverted cursor pixels in flight
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      horz_coord = 16'(40 + i); vert_coord = 16'd3; coord_valid = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_pixel", pixel_a, 0);
    check_eq("t6_rst_valid", pixel_valid_a, 0);
    check_eq("t6_rst_win", in_window_a, 0);
    rst = 1'b0; coord_valid = 1'b0;
    @(negedge clk);
    sweep(3, 40, 4, -1, 0, 0);
    check_eq("t6_valid_before_L", raw_pv_a[L-1], 0);
    check_eq("t6_valid_at_L", raw_pv_a[L], 1);
    check_eq("t6_blink_cleared", raw_pix_a[L], 0);
    check_eq("t6_win_at_L", raw_win_a[L], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_window_pipe.md
Name: text_window_pipe

Overview:
- Parametrised successor of the single-line VGA text pixel generator.
- Renders a ROWS x COLS character window at a programmable screen position, with integer glyph scaling and a blinking inverse-video cursor.
- Holds its own character RAM, which the CPU side writes, and drives an external font ROM through a fixed-latency address/data port.
- Sits between the VGA timing generator (coordinates in) and the colour mux (pixel out), with fixed, documented latency.

Parameters:
- FONT_W, 8, glyph width in pixels; power of two.
- FONT_H, 16, glyph height in pixels; power of two.
- COLS, 32, characters per text row.
- ROWS, 8, text rows.
- SCALE, 1, pixel replication factor in both axes; legal values 1, 2, 4.
- ROM_LAT, 1, font ROM read latency in cycles, from font_addr valid to font_row valid; range 1..3.
- BLINK_FRAMES, 30, frame_tick pulses per cursor blink half-period; must be >= 1.

Ports:
- clk  in  1  system/pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pos_x  in  16  window left edge, in screen pixels.
- pos_y  in  16  window top edge, in screen pixels.
- horz_coord  in  16  current pixel X from the VGA timing generator.
- vert_coord  in  16  current pixel Y from the VGA timing generator.
- coord_valid  in  1  horz_coord/vert_coord are in the active display area.
- frame_tick  in  1  one-cycle pulse per frame.
- wr_en  in  1  character RAM write strobe.
- wr_addr  in  clog2(ROWS*COLS)  write cell index = row*COLS + col.
- wr_data  in  8  character code.
- cursor_en  in  1  enable the cursor.
- cursor_addr  in  clog2(ROWS*COLS)  cursor cell index.
- font_addr  out  clog2(256*FONT_H)  font ROM address = code*FONT_H + glyph_row.
- font_row  in  FONT_W  ROM data, valid ROM_LAT cycles after font_addr; MSB = leftmost pixel.
- pixel  out  1  pixel is foreground.
- pixel_valid  out  1  coord_valid delayed by the pipeline.
- in_window  out  1  the delayed coordinate lies inside the window.

Behaviour:
- Window extent:
  - WIN_W = COLS*FONT_W*SCALE; WIN_H = ROWS*FONT_H*SCALE.
  - Inside when pos_x <= horz_coord < pos_x+WIN_W and pos_y <= vert_coord < pos_y+WIN_H.
  - All comparisons are unsigned 17-bit, so pos+WIN near 0xFFFF does not wrap.
- Stage S0 (registers the coordinates):
  - dx = horz_coord-pos_x, dy = vert_coord-pos_y.
  - gx = dx/SCALE, gy = dy/SCALE; shifts only.
  - col = gx/FONT_W, bit = gx%FONT_W, row = gy/FONT_H, glyph_row = gy%FONT_H.
  - Computes the inside flag. Outside cells never address the RAM with out-of-range indices; index forced to 0.
- Stage S1: synchronous character RAM read at row*COLS+col gives the code.
- Stage S2: font_addr registered.
- Stages S2+1 .. S2+ROM_LAT: side-band (bit, inside, valid, cursor-hit) delayed to match the ROM.
- Output stage: pixel = inside & coord_valid_d & (font_row[FONT_W-1-bit] XOR (cursor_hit & blink_phase)).
- Total latency, coordinate in to pixel/pixel_valid/in_window out: L = 3+ROM_LAT cycles. Fully pipelined, one pixel per cycle, no stalls.
- Character RAM:
  - ROWS*COLS x 8, one write port and one read port.
  - Write on the rising edge when wr_en=1.
  - Read and write to the same address in the same cycle returns the OLD data.
  - Contents are not cleared by rst.
- Cursor:
  - cursor_hit = cursor_en & (cell index == cursor_addr), evaluated in S1.
  - cursor_addr and cursor_en are sampled per pixel; a change takes effect on the next pixel entering S1.
- Blink counter:
  - On frame_tick, blink_cnt increments.
  - At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - When cursor_en=0, blink_cnt and blink_phase still run.
- Reset:
  - All pipeline valid/inside bits, pixel, pixel_valid, in_window, font_addr, blink_cnt and blink_phase go to 0.
  - rst asserted mid-frame: outputs are 0 from the cycle after the rst edge; the pipeline refills and the first valid output appears L cycles after rst deasserts with coord_valid=1.
- coord_valid=0: the pixel flows through with valid=0; pixel=0 and in_window=0 at output.
- wr_addr >= ROWS*COLS: write ignored.
- cursor_addr >= ROWS*COLS: no hit.

Test Plan:
1. Reset, then write 0x41 to cell 0 (pos_x=pos_y=0, SCALE=1). Sweep X 0..7 at Y=3 with a model ROM (ROM_LAT=1) whose row 3 of 'A' is 0x66 -> pixel sequence 0,1,1,0,0,1,1,0 appears exactly 4 cycles after each coordinate.
2. pos_x=100, pos_y=50, COLS=32 -> in_window=1 for X=100..355 and 0 at X=99 and X=356; at Y=50+128 it drops to 0; latency matches L.
3. SCALE=2: glyph row 0x80 at cell 0 -> X=0,1 give pixel=1, X=2..15 give 0; font_addr uses glyph_row = Y/2.
4. cursor_en=1, cursor_addr=5, BLINK_FRAMES=2 -> after 2 frame_ticks, cell 5 renders inverted (blank cell all 1); after 2 more ticks it renders normal; cell 4 is never affected.
5. Write cell 3 and read cell 3 in the same cycle -> old code rendered; next scanline shows the new code.
6. Assert rst mid-line with pixels in flight -> pixel/pixel_valid are 0 the next cycle; after release, first valid output exactly L cycles after the first coord_valid; blink_phase reads 0.
